fwd_hazard_unit: RTL and testbench

Parametrised forwarding and load-use hazard unit for the pipelined core. It keeps its own shadow copy of the EX, MEM and WB stage destination/control fields, fed from the decode stage. From these it produces per-operand bypass selects for the EX stage and a stall request for the fetch/decode stages. Load-use stalls are counted by a small FSM of configurable length, and a saturating stall counter is kept for performance debug.

---
 rtl/fwd_hazard_unit.sv | 172 +++++++++++++++++
 tb/tb_fwd_hazard_unit.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard unit: shadows the EX/MEM/WB destination fields and drives EX bypass selects and the fetch/decode stall.
// Latency: stall is combinational from the decode slot plus registered shadow state; fwd_sel is combinational from registered state only.
// Backpressure: a load-use hazard holds PC and IF/ID for LOAD_STALL cycles with bubbles into EX; flush overrides any stall.
module fwd_hazard_unit #(
  parameter int ADDR_W     = 5,
  parameter int NPORTS     = 2,
  parameter int LOAD_STALL = 1,
  parameter int CNT_W      = 16
) (
  input  logic                     clk,
  input  logic                     arst,
  input  logic                     id_valid,
  input  logic [NPORTS*ADDR_W-1:0] id_rs,
  input  logic [NPORTS-1:0]        id_rs_used,
  input  logic [ADDR_W-1:0]        id_rd,
  input  logic                     id_regwrite,
  input  logic                     id_memread,
  input  logic                     flush,
  output logic                     stall,
  output logic [NPORTS*2-1:0]      fwd_sel,
  output logic [CNT_W-1:0]         stall_count
);

  // Wide enough to hold LOAD_STALL-1 for the WAIT countdown.
  localparam int CW = (LOAD_STALL > 1) ? $clog2(LOAD_STALL + 1) : 1;

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_MEM = 2'b10;
  localparam logic [1:0] SEL_WB  = 2'b01;

  // EX needs the source fields for bypass selection and memread for load-use detection.
  typedef struct packed {
    logic                     valid;
    logic [ADDR_W-1:0]        rd;
    logic                     regwrite;
    logic                     memread;
    logic [NPORTS*ADDR_W-1:0] rs;
    logic [NPORTS-1:0]        rs_used;
  } ex_ent_t;

  // Later stages only matter as producers.
  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] rd;
    logic              regwrite;
  } dst_ent_t;

  typedef enum logic {
    S_RUN  = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  ex_ent_t  ex_q,  ex_d;
  dst_ent_t mem_q, mem_d;
  dst_ent_t wb_q,  wb_d;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q,   cnt_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;

  logic rs_hit;
  logic load_use;
  logic stall_int;

  // Load-use: the instruction in EX is a load whose destination is read by the decode slot.
  always_comb begin
    rs_hit = 1'b0;
    for (int i = 0; i < NPORTS; i++) begin
      if (id_rs_used[i] && (id_rs[i*ADDR_W +: ADDR_W] == ex_q.rd)) begin
        rs_hit = 1'b1;
      end
    end
    load_use = id_valid && ex_q.valid && ex_q.memread && ex_q.regwrite &&
               (ex_q.rd != '0) && rs_hit;
  end

  // Stall FSM: RUN raises the first bubble; WAIT covers the remaining LOAD_STALL-1. Flush always wins.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    stall_int = 1'b0;
    case (state_q)
      S_RUN: begin
        stall_int = load_use && !flush;
        if (stall_int && (LOAD_STALL > 1)) begin
          state_d = S_WAIT;
          cnt_d   = CW'(LOAD_STALL - 1);
        end
      end
      S_WAIT: begin
        if (flush) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end else begin
          stall_int = 1'b1;
          cnt_d     = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_d = S_RUN;
          end
        end
      end
      default: begin
        state_d = S_RUN;
        cnt_d   = '0;
      end
    endcase
  end

  // Shadow pipeline advance: decode enters EX unless stalled or flushed, in which case EX takes a cleared bubble.
  always_comb begin
    ex_d = '0;
    if (id_valid && !stall_int && !flush) begin
      ex_d.valid    = 1'b1;
      ex_d.rd       = id_rd;
      ex_d.regwrite = id_regwrite;
      ex_d.memread  = id_memread;
      ex_d.rs       = id_rs;
      ex_d.rs_used  = id_rs_used;
    end
    mem_d.valid    = ex_q.valid;
    mem_d.rd       = ex_q.rd;
    mem_d.regwrite = ex_q.regwrite;
    wb_d           = mem_q;
  end

  // Stall counter saturates at all-ones rather than wrapping.
  always_comb begin
    stall_count_d = stall_count_q;
    if (stall_int && (stall_count_q != {CNT_W{1'b1}})) begin
      stall_count_d = stall_count_q + CNT_W'(1);
    end
  end

  // All state registers share one async reset so arst empties the pipe and parks the FSM at once.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      ex_q          <= '0;
      mem_q         <= '0;
      wb_q          <= '0;
      state_q       <= S_RUN;
      cnt_q         <= '0;
      stall_count_q <= '0;
    end else begin
      ex_q          <= ex_d;
      mem_q         <= mem_d;
      wb_q          <= wb_d;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      stall_count_q <= stall_count_d;
    end
  end

  // Bypass select per EX operand from registered state only; the nearer producer (EX/MEM) wins and r0 never forwards.
  always_comb begin
    fwd_sel = '0;
    for (int i = 0; i < NPORTS; i++) begin
      if (ex_q.rs_used[i] && mem_q.valid && mem_q.regwrite && (mem_q.rd != '0) &&
          (mem_q.rd == ex_q.rs[i*ADDR_W +: ADDR_W])) begin
        fwd_sel[i*2 +: 2] = SEL_MEM;
      end else if (ex_q.rs_used[i] && wb_q.valid && wb_q.regwrite && (wb_q.rd != '0) &&
                   (wb_q.rd == ex_q.rs[i*ADDR_W +: ADDR_W])) begin
        fwd_sel[i*2 +: 2] = SEL_WB;
      end else begin
        fwd_sel[i*2 +: 2] = SEL_RF;
      end
    end
  end

  assign stall       = stall_int;
  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: three instances share one decode stream.
// u_a: LOAD_STALL=1, u_b: LOAD_STALL=3, u_c: LOAD_STALL=1 with a 4-bit stall counter.
// Inputs change 1 time unit after a rising edge; outputs are sampled on the falling edge.
module tb_fwd_hazard_unit;

  logic       clk;
  logic       arst;
  logic       id_valid;
  logic [9:0] id_rs;
  logic [1:0] id_rs_used;
  logic [4:0] id_rd;
  logic       id_regwrite;
  logic       id_memread;
  logic       flush;

  logic        stall_a, stall_b, stall_c;
  logic [3:0]  fwd_a, fwd_b, fwd_c;
  logic [15:0] cnt_a, cnt_b;
  logic [3:0]  cnt_c;

  int total;
  int passed;
  int failed;

  fwd_hazard_unit #(.ADDR_W(5), .NPORTS(2), .LOAD_STALL(1), .CNT_W(16)) u_a (
    .clk(clk), .arst(arst), .id_valid(id_valid), .id_rs(id_rs), .id_rs_used(id_rs_used),
    .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread), .flush(flush),
    .stall(stall_a), .fwd_sel(fwd_a), .stall_count(cnt_a)
  );

  fwd_hazard_unit #(.ADDR_W(5), .NPORTS(2), .LOAD_STALL(3), .CNT_W(16)) u_b (
    .clk(clk), .arst(arst), .id_valid(id_valid), .id_rs(id_rs), .id_rs_used(id_rs_used),
    .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread), .flush(flush),
    .stall(stall_b), .fwd_sel(fwd_b), .stall_count(cnt_b)
  );

  fwd_hazard_unit #(.ADDR_W(5), .NPORTS(2), .LOAD_STALL(1), .CNT_W(4)) u_c (
    .clk(clk), .arst(arst), .id_valid(id_valid), .id_rs(id_rs), .id_rs_used(id_rs_used),
    .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread), .flush(flush),
    .stall(stall_c), .fwd_sel(fwd_c), .stall_count(cnt_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs0, input logic [4:0] rs1,
                        input logic [1:0] used, input logic [4:0] rd,
                        input logic rw, input logic mr, input logic fl);
    id_valid    = v;
    id_rs       = {rs1, rs0};
    id_rs_used  = used;
    id_rd       = rd;
    id_regwrite = rw;
    id_memread  = mr;
    flush       = fl;
  endtask

  task automatic nop();
    set_id(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic reset_pulse();
    arst = 1'b1;
    tick();
    arst = 1'b0;
    nop();
    tick();
  endtask

  initial begin
    total  = 0;
    passed = 0;
    failed = 0;
    arst   = 1'b1;
    nop();
    tick();
    tick();

    // Reset state.
    chk("rst_stall_a", stall_a, 0);
    chk("rst_fwd_a",   fwd_a,   0);
    chk("rst_cnt_a",   cnt_a,   0);
    chk("rst_stall_b", stall_b, 0);
    chk("rst_cnt_b",   cnt_b,   0);
    chk("rst_cnt_c",   cnt_c,   0);
    arst = 1'b0;
    tick();

    // Back-to-back ALU dependency: add r3<-r1,r2 ; sub r4<-r3,r5.
    set_id(1, 5'd1, 5'd2, 2'b11, 5'd3, 1, 0, 0); sample(); chk("alu_p_stall", stall_a, 0); tick();
    set_id(1, 5'd3, 5'd5, 2'b11, 5'd4, 1, 0, 0); sample(); chk("alu_c_stall", stall_a, 0); tick();
    nop(); sample(); chk("alu_fwd", fwd_a, 4'b0010); tick();

    // Distance-2 producer of r3.
    set_id(1, 5'd1, 5'd2, 2'b11, 5'd3, 1, 0, 0); tick();
    set_id(1, 5'd1, 5'd2, 2'b11, 5'd9, 1, 0, 0); tick();
    set_id(1, 5'd3, 5'd5, 2'b11, 5'd4, 1, 0, 0); tick();
    nop(); sample(); chk("dist2_fwd", fwd_a, 4'b0001); tick();

    // r3 produced at both distance 1 and 2: EX/MEM must win.
    set_id(1, 5'd1, 5'd2, 2'b11, 5'd3, 1, 0, 0); tick();
    set_id(1, 5'd2, 5'd1, 2'b11, 5'd3, 1, 0, 0); tick();
    set_id(1, 5'd3, 5'd5, 2'b11, 5'd4, 1, 0, 0); tick();
    nop(); sample(); chk("double_fwd", fwd_a, 4'b0010); tick();

    // Load-use, one bubble: lw r7 ; add r8<-r7,r7.
    set_id(1, 5'd1, 5'd0, 2'b01, 5'd7, 1, 1, 0); sample(); chk("lu1_ld_stall", stall_a, 0); tick();
    set_id(1, 5'd7, 5'd7, 2'b11, 5'd8, 1, 0, 0); sample(); chk("lu1_stall", stall_a, 1); tick();
    sample(); chk("lu1_release", stall_a, 0); tick();
    nop(); sample(); chk("lu1_fwd", fwd_a, 4'b0101); chk("lu1_count", cnt_a, 1); tick();

    // Register 0: load to r0 followed by a reader of r0.
    set_id(1, 5'd1, 5'd2, 2'b11, 5'd0, 1, 1, 0); tick();
    set_id(1, 5'd0, 5'd0, 2'b11, 5'd4, 1, 0, 0); sample(); chk("r0_stall", stall_a, 0); tick();
    nop(); sample(); chk("r0_fwd", fwd_a, 4'b0000); tick();

    // Matching addresses on ports that are not read.
    set_id(1, 5'd1, 5'd0, 2'b01, 5'd7, 1, 1, 0); tick();
    set_id(1, 5'd7, 5'd7, 2'b00, 5'd8, 1, 0, 0); sample(); chk("unused_stall", stall_a, 0); tick();
    nop(); sample(); chk("unused_fwd", fwd_a, 4'b0000); tick();

    // Flush coincident with a load-use hazard: no stall, bubble into EX.
    set_id(1, 5'd1, 5'd0, 2'b01, 5'd7, 1, 1, 0); tick();
    set_id(1, 5'd7, 5'd7, 2'b11, 5'd8, 1, 0, 1); sample(); chk("flush_lu_stall", stall_a, 0); tick();
    nop(); sample(); chk("flush_bubble_fwd", fwd_a, 4'b0000); chk("flush_count", cnt_a, 1); tick();

    // Load-use with three bubbles.
    reset_pulse();
    set_id(1, 5'd1, 5'd0, 2'b01, 5'd7, 1, 1, 0); sample(); chk("lu3_ld_stall", stall_b, 0); tick();
    set_id(1, 5'd7, 5'd7, 2'b11, 5'd8, 1, 0, 0); sample(); chk("lu3_s0", stall_b, 1); tick();
    sample(); chk("lu3_s1", stall_b, 1); tick();
    sample(); chk("lu3_s2", stall_b, 1); tick();
    sample(); chk("lu3_s3", stall_b, 0); tick();
    nop(); sample(); chk("lu3_count", cnt_b, 3); chk("lu3_fwd", fwd_b, 4'b0000); tick();

    // Flush in the second stall cycle drops stall and returns to RUN.
    set_id(1, 5'd1, 5'd0, 2'b01, 5'd7, 1, 1, 0); tick();
    set_id(1, 5'd7, 5'd7, 2'b11, 5'd8, 1, 0, 0); sample(); chk("fw_s0", stall_b, 1); tick();
    set_id(1, 5'd7, 5'd7, 2'b11, 5'd8, 1, 0, 1); sample(); chk("fw_flush_stall", stall_b, 0); tick();
    nop(); sample(); chk("fw_run_stall", stall_b, 0); chk("fw_count", cnt_b, 4); tick();

    // Asynchronous reset in the middle of WAIT.
    set_id(1, 5'd1, 5'd0, 2'b01, 5'd7, 1, 1, 0); tick();
    set_id(1, 5'd7, 5'd7, 2'b11, 5'd8, 1, 0, 0); sample(); chk("ar_s0", stall_b, 1); tick();
    #2;
    arst = 1'b1;
    #1;
    chk("ar_stall", stall_b, 0);
    chk("ar_fwd",   fwd_b,   0);
    chk("ar_count", cnt_b,   0);
    chk("ar_count_a", cnt_a, 0);
    tick();
    arst = 1'b0;
    sample(); chk("ar_resid0", stall_b, 0); tick();
    sample(); chk("ar_resid1", stall_b, 0); tick();

    // Saturation: 20 load-use stalls.
    reset_pulse();
    for (int n = 0; n < 20; n++) begin
      set_id(1, 5'd1, 5'd0, 2'b01, 5'd7, 1, 1, 0); sample(); chk("sat_ld_stall", stall_c, 0); tick();
      set_id(1, 5'd7, 5'd7, 2'b11, 5'd8, 1, 0, 0); sample(); chk("sat_use_stall", stall_c, 1); tick();
    end
    nop(); sample(); chk("sat_count_c", cnt_c, 4'hF); chk("sat_count_a", cnt_a, 20); tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
